// File: rtl/mca_adlib_pkg.sv
// ---------------------------------------------------------------------------
// mca_adlib_pkg
// Shared definitions for the MCA AdLib-compatible FM card slave interface.
//   - Default adapter ID and YM3812 I/O base.
//   - POS register offsets.
//   - Latched bus status encoding and the wait-state FSM encoding.
//   - decode_status(): folds the two MCA status lines into one status value.
// ---------------------------------------------------------------------------
package mca_adlib_pkg;

  localparam logic [15:0] DEF_ADAPTER_ID = 16'h70D7;
  localparam logic [15:0] DEF_IO_BASE    = 16'h0388;
  localparam int          DEF_WAIT_CLKS  = 4;

  localparam logic [2:0] POS_ID_LO = 3'd0;
  localparam logic [2:0] POS_ID_HI = 3'd1;
  localparam logic [2:0] POS_EN    = 3'd2;
  localparam logic [2:0] POS_AUX   = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } mca_status_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COUNT,
    W_DONE
  } wait_state_e;

  // A cycle is only a read or a write when exactly one of the two status
  // lines was active; both or neither means "do nothing".
  function automatic mca_status_e decode_status(input logic rd, input logic wr);
    if (rd && !wr) begin
      return RD;
    end else if (wr && !rd) begin
      return WR;
    end else begin
      return IDLE;
    end
  endfunction

endpackage

// File: rtl/mca_pos_regs.sv
// ---------------------------------------------------------------------------
// mca_pos_regs
// POS setup register file and readback mux for the AdLib MCA card.
//   POS 0/1 : read-only adapter ID (low/high byte)
//   POS 2   : enable register, bit 0 = card enable (cden)
//   POS 3   : spare read/write register
//   POS 4-7 : read as 8'hFF
// Ports:
//   clk, chreset_l : clock and asynchronous active-low reset
//   wr_en          : POS write strobe, sampled every clk
//   offset         : POS register offset (latched address bits 2:0)
//   wdata          : write data taken straight from the MCA data bus
//   rdata          : readback value for the current offset
//   cden           : card enable (POS 2 bit 0)
// ---------------------------------------------------------------------------
module mca_pos_regs
  import mca_adlib_pkg::*;
#(
  parameter logic [15:0] ADAPTER_ID = DEF_ADAPTER_ID
) (
  input  logic       clk,
  input  logic       chreset_l,
  input  logic       wr_en,
  input  logic [2:0] offset,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       cden
);

  logic [7:0] pos_en;
  logic [7:0] pos_aux;

  // Writable POS registers. The write strobe stays up for the whole data
  // phase, so the register is rewritten every clock and the last sample
  // before the command ends is the one that sticks.
  always_ff @(posedge clk or negedge chreset_l) begin
    if (!chreset_l) begin
      pos_en  <= 8'h00;
      pos_aux <= 8'h00;
    end else if (wr_en) begin
      if (offset == POS_EN) begin
        pos_en <= wdata;
      end else if (offset == POS_AUX) begin
        pos_aux <= wdata;
      end
    end
  end

  // Readback mux; unimplemented offsets float high like an empty bus.
  always_comb begin
    rdata = 8'hFF;
    case (offset)
      POS_ID_LO: rdata = ADAPTER_ID[7:0];
      POS_ID_HI: rdata = ADAPTER_ID[15:8];
      POS_EN:    rdata = pos_en;
      POS_AUX:   rdata = pos_aux;
      default:   rdata = 8'hFF;
    endcase
  end

  assign cden = pos_en[0];

endmodule

// File: rtl/mca_adlib_if.sv
// ---------------------------------------------------------------------------
// mca_adlib_if
// Micro Channel slave interface for an AdLib-compatible YM3812 FM card.
// Decodes I/O cycles at IO_BASE/IO_BASE+1, hosts the POS setup registers and
// produces the YM3812 strobes plus external data buffer controls.
// Ports:
//   clk, chreset_l          : clock, asynchronous active-low reset
//   cd_setup_l, adl_l, cmd  : MCA setup select, address latch, command
//   m_io, s0_w_l, s1_r_l    : MCA memory/IO and status lines
//   a[15:0], d[7:0]         : MCA address, MCA data (driven on POS reads only)
//   cd_sfdbk, cd_chrdy_l    : card selected feedback, channel ready
//   ior_l, iow_l, ym_a0,
//   ym_cs_l                 : YM3812 strobes, register select, chip select
//   cden                    : card enabled (POS 2 bit 0)
//   bufen_l, bufdir         : external buffer enable and direction
// Optional build macro:
//   MCADLIB_CHRDY_WAIT_EN   : when defined, each YM access pulls cd_chrdy_l
//                             low for WAIT_CLKS clocks; otherwise the card
//                             is always ready.
// ---------------------------------------------------------------------------
module mca_adlib_if
  import mca_adlib_pkg::*;
#(
  parameter logic [15:0] ADAPTER_ID = DEF_ADAPTER_ID,
  parameter logic [15:0] IO_BASE    = DEF_IO_BASE,
  parameter int          WAIT_CLKS  = DEF_WAIT_CLKS
) (
  input  logic        clk,
  input  logic        chreset_l,
  input  logic        cd_setup_l,
  input  logic        adl_l,
  input  logic        cmd,
  input  logic        m_io,
  input  logic        s0_w_l,
  input  logic        s1_r_l,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  output logic        cd_sfdbk,
  output logic        cd_chrdy_l,
  output logic        ior_l,
  output logic        iow_l,
  output logic        ym_a0,
  output logic        ym_cs_l,
  output logic        cden,
  output logic        bufen_l,
  output logic        bufdir
);

  logic [15:0] lat_a;
  logic        lat_mio;
  logic        lat_setup;
  mca_status_e lat_status;

  logic        io_hit;
  logic        ym_go;
  logic        pos_rd_go;
  logic        pos_wr_go;
  logic [7:0]  pos_rdata;
  logic [7:0]  d_out;
  logic        d_oe;

  // Address phase capture. Address and status are only trusted while
  // adl_l is low; after it rises the latched copy is held so late status
  // changes on the bus cannot alter the cycle in progress.
  always_ff @(posedge clk or negedge chreset_l) begin
    if (!chreset_l) begin
      lat_a      <= 16'h0000;
      lat_mio    <= 1'b1;
      lat_setup  <= 1'b0;
      lat_status <= IDLE;
    end else if (!adl_l) begin
      lat_a      <= a;
      lat_mio    <= m_io;
      lat_setup  <= !cd_setup_l;
      lat_status <= decode_status(!s1_r_l, !s0_w_l);
    end
  end

  // Address decode from the latched cycle. Bit 0 selects the YM3812
  // register/data port, so it is left out of the compare.
  always_comb begin
    io_hit    = !lat_setup && cden && !lat_mio && (lat_a[15:1] == IO_BASE[15:1]);
    ym_go     = io_hit && !cmd && (lat_status != IDLE);
    pos_rd_go = lat_setup && !cmd && (lat_status == RD);
    pos_wr_go = lat_setup && !cmd && (lat_status == WR);
  end

  assign cd_sfdbk = io_hit;

  mca_pos_regs #(
    .ADAPTER_ID (ADAPTER_ID)
  ) u_pos_regs (
    .clk       (clk),
    .chreset_l (chreset_l),
    .wr_en     (pos_wr_go),
    .offset    (lat_a[2:0]),
    .wdata     (d),
    .rdata     (pos_rdata),
    .cden      (cden)
  );

  // POS readback driver. The card only drives the MCA data bus for POS
  // reads; YM3812 data always travels through the external buffer.
  always_ff @(posedge clk or negedge chreset_l) begin
    if (!chreset_l) begin
      d_oe  <= 1'b0;
      d_out <= 8'h00;
    end else begin
      d_oe  <= pos_rd_go;
      d_out <= pos_rdata;
    end
  end

  assign d = d_oe ? d_out : 8'hzz;

  // YM3812 strobes and buffer controls, registered from the sampled
  // command. Everything falls back to idle on the first clock that sees
  // cmd high, or as soon as the card is disabled.
  always_ff @(posedge clk or negedge chreset_l) begin
    if (!chreset_l) begin
      ym_cs_l <= 1'b1;
      bufen_l <= 1'b1;
      ior_l   <= 1'b1;
      iow_l   <= 1'b1;
      ym_a0   <= 1'b0;
      bufdir  <= 1'b0;
    end else begin
      ym_cs_l <= !ym_go;
      bufen_l <= !ym_go;
      ior_l   <= !(ym_go && (lat_status == RD));
      iow_l   <= !(ym_go && (lat_status == WR));
      ym_a0   <= ym_go && lat_a[0];
      bufdir  <= ym_go && (lat_status == RD);
    end
  end

`ifdef MCADLIB_CHRDY_WAIT_EN
  localparam int WAIT_W = (WAIT_CLKS > 1) ? $clog2(WAIT_CLKS) : 1;

  wait_state_e       wait_state;
  logic [WAIT_W-1:0] wait_cnt;

  // Wait-state generator. The first clock of a YM access pulls the channel
  // not-ready and loads the counter; ready returns after WAIT_CLKS clocks.
  // If the command ends early (or the card is disabled) the wait is dropped.
  // W_DONE holds off a restart until the current access has finished.
  always_ff @(posedge clk or negedge chreset_l) begin
    if (!chreset_l) begin
      wait_state <= W_IDLE;
      wait_cnt   <= '0;
      cd_chrdy_l <= 1'b1;
    end else begin
      case (wait_state)
        W_IDLE: begin
          if (ym_go) begin
            wait_state <= W_COUNT;
            wait_cnt   <= WAIT_W'(WAIT_CLKS - 1);
            cd_chrdy_l <= 1'b0;
          end
        end
        W_COUNT: begin
          if (!ym_go) begin
            wait_state <= W_IDLE;
            cd_chrdy_l <= 1'b1;
          end else if (wait_cnt == '0) begin
            wait_state <= W_DONE;
            cd_chrdy_l <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        W_DONE: begin
          if (!ym_go) begin
            wait_state <= W_IDLE;
          end
        end
        default: begin
          wait_state <= W_IDLE;
          cd_chrdy_l <= 1'b1;
        end
      endcase
    end
  end
`else
  // Wait insertion compiled out: the card is always ready. WAIT_CLKS is
  // folded in only so the parameter stays referenced in this build.
  assign cd_chrdy_l = 1'b1 | (WAIT_CLKS == 0);
`endif

endmodule

// File: tb/tb_mca_adlib_if.sv
// ---------------------------------------------------------------------------
// tb_mca_adlib_if
// Self-checking bench for mca_adlib_if. A transaction-level model tracks the
// POS contents and the latched bus cycle and predicts every output each
// clock; directed bus cycles add hand-computed literal expectations.
// Honours MCADLIB_CHRDY_WAIT_EN for the channel-ready expectations.
// ---------------------------------------------------------------------------
module tb_mca_adlib_if;

  localparam logic [7:0] YM_STATUS = 8'h06;
  localparam int         EXP_WAIT  = 4;

  typedef struct {
    logic [7:0] d;
    logic       cs_l;
    logic       a0;
    logic       ior_l;
    logic       iow_l;
    logic       bufen_l;
    logic       bufdir;
    logic       sfdbk;
  } snap_t;

  logic        clk;
  logic        chreset_l;
  logic        cd_setup_l;
  logic        adl_l;
  logic        cmd;
  logic        m_io;
  logic        s0_w_l;
  logic        s1_r_l;
  logic [15:0] a;
  wire  [7:0]  d;
  logic        cd_sfdbk;
  logic        cd_chrdy_l;
  logic        ior_l;
  logic        iow_l;
  logic        ym_a0;
  logic        ym_cs_l;
  logic        cden;
  logic        bufen_l;
  logic        bufdir;

  logic [7:0]  tb_d;
  logic        tb_d_oe;
  logic [7:0]  ym_latch;

  int          checks;
  int          errors;

  mca_adlib_if dut (
    .clk        (clk),
    .chreset_l  (chreset_l),
    .cd_setup_l (cd_setup_l),
    .adl_l      (adl_l),
    .cmd        (cmd),
    .m_io       (m_io),
    .s0_w_l     (s0_w_l),
    .s1_r_l     (s1_r_l),
    .a          (a),
    .d          (d),
    .cd_sfdbk   (cd_sfdbk),
    .cd_chrdy_l (cd_chrdy_l),
    .ior_l      (ior_l),
    .iow_l      (iow_l),
    .ym_a0      (ym_a0),
    .ym_cs_l    (ym_cs_l),
    .cden       (cden),
    .bufen_l    (bufen_l),
    .bufdir     (bufdir)
  );

  // Bus master data driver and a minimal YM3812 behind the buffer: it
  // returns a fixed status byte on reads and remembers the last write.
  assign d = tb_d_oe ? tb_d : 8'hzz;
  assign d = (!bufen_l && bufdir && !ym_cs_l && !ior_l) ? YM_STATUS : 8'hzz;

  always @(negedge clk) begin
    if (!ym_cs_l && !iow_l && !bufen_l && !bufdir) begin
      ym_latch = d;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: the card as seen from the bus. t_* hold the cycle
  // most recently announced on the address phase, m_pos the POS space.
  // ---------------------------------------------------------------------
  logic [7:0]  m_pos [8];
  logic [15:0] t_addr;
  logic        t_setup, t_mio, t_rd, t_wr;
  logic        exp_cs_l, exp_bufen_l, exp_ior_l, exp_iow_l, exp_a0, exp_bufdir;
  logic        exp_sfdbk, exp_drive;
  logic [7:0]  exp_dval;
  int          m_run;
  bit          armed;

  function automatic bit model_hit();
    return !t_setup && m_pos[2][0] && !t_mio && (t_addr == 16'h0388 || t_addr == 16'h0389);
  endfunction

  always @(posedge clk) begin : model_b
    bit ym;
    if (!chreset_l) begin
      m_pos[0] = 8'hD7; m_pos[1] = 8'h70; m_pos[2] = 8'h00; m_pos[3] = 8'h00;
      for (int i = 4; i < 8; i++) m_pos[i] = 8'hFF;
      t_addr = 16'h0000; t_setup = 1'b0; t_mio = 1'b1; t_rd = 1'b0; t_wr = 1'b0;
      exp_cs_l = 1'b1; exp_bufen_l = 1'b1; exp_ior_l = 1'b1; exp_iow_l = 1'b1;
      exp_a0 = 1'b0; exp_bufdir = 1'b0; exp_sfdbk = 1'b0; exp_drive = 1'b0;
      exp_dval = 8'h00; m_run = 0; armed = 1'b1;
    end else begin
      ym          = model_hit() && !cmd && (t_rd != t_wr);
      exp_cs_l    = !ym;
      exp_bufen_l = !ym;
      exp_ior_l   = !(ym && t_rd);
      exp_iow_l   = !(ym && t_wr);
      exp_a0      = ym && t_addr[0];
      exp_bufdir  = ym && t_rd;
      m_run       = ym ? m_run + 1 : 0;
      exp_drive   = t_setup && t_rd && !t_wr && !cmd;
      exp_dval    = m_pos[t_addr[2:0]];
      if (t_setup && t_wr && !t_rd && !cmd && (t_addr[2:0] == 3'd2 || t_addr[2:0] == 3'd3))
        m_pos[t_addr[2:0]] = d;
      if (!adl_l) begin
        t_addr = a; t_setup = !cd_setup_l; t_mio = m_io; t_rd = !s1_r_l; t_wr = !s0_w_l;
      end
      exp_sfdbk = model_hit();
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_chrdy;
    if (chreset_l && armed) begin
`ifdef MCADLIB_CHRDY_WAIT_EN
      exp_chrdy = !(m_run >= 1 && m_run <= EXP_WAIT);
`else
      exp_chrdy = 1'b1;
`endif
      checkOutput("cyc_ym_cs_l", 16'(ym_cs_l), 16'(exp_cs_l));
      checkOutput("cyc_bufen_l", 16'(bufen_l), 16'(exp_bufen_l));
      checkOutput("cyc_ior_l", 16'(ior_l), 16'(exp_ior_l));
      checkOutput("cyc_iow_l", 16'(iow_l), 16'(exp_iow_l));
      checkOutput("cyc_ym_a0", 16'(ym_a0), 16'(exp_a0));
      checkOutput("cyc_bufdir", 16'(bufdir), 16'(exp_bufdir));
      checkOutput("cyc_sfdbk", 16'(cd_sfdbk), 16'(exp_sfdbk));
      checkOutput("cyc_cden", 16'(cden), 16'(m_pos[2][0]));
      checkOutput("cyc_chrdy_l", 16'(cd_chrdy_l), 16'(exp_chrdy));
      if (!tb_d_oe && !exp_bufen_l && exp_bufdir)
        checkOutput("cyc_d_ym", 16'(d), 16'(YM_STATUS));
      else if (!tb_d_oe && exp_drive)
        checkOutput("cyc_d_pos", 16'(d), 16'(exp_dval));
    end
  end

  // One complete MCA bus cycle: address phase, status lines released
  // after adl_l rises, six clocks of data phase, then cmd back high.
  task automatic applyStimulus(input logic setup, input logic mio, input logic rd,
                               input logic wr, input logic [15:0] addr,
                               input logic [7:0] wdata, output snap_t s,
                               output int chrdy_lows);
    chrdy_lows = 0;
    @(posedge clk); #1;
    cd_setup_l = !setup; m_io = mio; s0_w_l = !wr; s1_r_l = !rd; a = addr; adl_l = 1'b0;
    @(posedge clk); #1;
    adl_l = 1'b1; s0_w_l = 1'b1; s1_r_l = 1'b1; cd_setup_l = 1'b1;
    cmd = 1'b0;
    if (wr) begin
      tb_d = wdata; tb_d_oe = 1'b1;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!cd_chrdy_l) chrdy_lows++;
      s.d = d; s.cs_l = ym_cs_l; s.a0 = ym_a0; s.ior_l = ior_l; s.iow_l = iow_l;
      s.bufen_l = bufen_l; s.bufdir = bufdir; s.sfdbk = cd_sfdbk;
    end
    @(posedge clk); #1;
    cmd = 1'b1;
    @(negedge clk);
    if (!cd_chrdy_l) chrdy_lows++;
    @(posedge clk); #1;
    tb_d_oe = 1'b0; a = 16'h0000; m_io = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    snap_t s;
    int    lows;
    int    exp_lows;
    checks = 0; errors = 0;
    chreset_l = 1'b0; cd_setup_l = 1'b1; adl_l = 1'b1; cmd = 1'b1; m_io = 1'b1;
    s0_w_l = 1'b1; s1_r_l = 1'b1; a = 16'h0000; tb_d = 8'h00; tb_d_oe = 1'b0;
    ym_latch = 8'h00;
`ifdef MCADLIB_CHRDY_WAIT_EN
    exp_lows = EXP_WAIT;
`else
    exp_lows = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cden", 16'(cden), 16'h0);
    checkOutput("rst_ym_cs_l", 16'(ym_cs_l), 16'h1);
    checkOutput("rst_ior_l", 16'(ior_l), 16'h1);
    checkOutput("rst_iow_l", 16'(iow_l), 16'h1);
    checkOutput("rst_bufen_l", 16'(bufen_l), 16'h1);
    checkOutput("rst_chrdy_l", 16'(cd_chrdy_l), 16'h1);
    checkOutput("rst_sfdbk", 16'(cd_sfdbk), 16'h0);
    checkOutput("rst_bufdir", 16'(bufdir), 16'h0);
    @(posedge clk); #1;
    chreset_l = 1'b1;

    $display("[TB] POS ID readback");
    applyStimulus(1, 1, 1, 0, 16'h0000, 8'h00, s, lows);
    checkOutput("pos0_d", 16'(s.d), 16'h00D7);
    checkOutput("pos0_cs_l", 16'(s.cs_l), 16'h1);
    applyStimulus(1, 1, 1, 0, 16'h0001, 8'h00, s, lows);
    checkOutput("pos1_d", 16'(s.d), 16'h0070);
    checkOutput("pos1_cden", 16'(cden), 16'h0);

    $display("[TB] POS writes and readback");
    applyStimulus(1, 1, 0, 1, 16'h0003, 8'hC0, s, lows);
    applyStimulus(1, 1, 0, 1, 16'h0002, 8'h01, s, lows);
    checkOutput("pos_en_cden", 16'(cden), 16'h1);
    applyStimulus(1, 1, 1, 0, 16'h0002, 8'h00, s, lows);
    checkOutput("pos2_d", 16'(s.d), 16'h0001);
    applyStimulus(1, 1, 1, 0, 16'h0003, 8'h00, s, lows);
    checkOutput("pos3_d", 16'(s.d), 16'h00C0);
    applyStimulus(1, 1, 1, 0, 16'h0005, 8'h00, s, lows);
    checkOutput("pos5_d", 16'(s.d), 16'h00FF);

    $display("[TB] YM read at 0x388");
    applyStimulus(0, 0, 1, 0, 16'h0388, 8'h00, s, lows);
    checkOutput("ymrd_cs_l", 16'(s.cs_l), 16'h0);
    checkOutput("ymrd_a0", 16'(s.a0), 16'h0);
    checkOutput("ymrd_ior_l", 16'(s.ior_l), 16'h0);
    checkOutput("ymrd_iow_l", 16'(s.iow_l), 16'h1);
    checkOutput("ymrd_bufen_l", 16'(s.bufen_l), 16'h0);
    checkOutput("ymrd_bufdir", 16'(s.bufdir), 16'h1);
    checkOutput("ymrd_sfdbk", 16'(s.sfdbk), 16'h1);
    checkOutput("ymrd_d", 16'(s.d), 16'(YM_STATUS));
    checkOutput("ymrd_chrdy_lows", 16'(lows), 16'(exp_lows));
    checkOutput("ymrd_after_ior_l", 16'(ior_l), 16'h1);
    checkOutput("ymrd_after_cs_l", 16'(ym_cs_l), 16'h1);

    $display("[TB] YM write at 0x389");
    applyStimulus(0, 0, 0, 1, 16'h0389, 8'hCC, s, lows);
    checkOutput("ymwr_a0", 16'(s.a0), 16'h1);
    checkOutput("ymwr_iow_l", 16'(s.iow_l), 16'h0);
    checkOutput("ymwr_bufdir", 16'(s.bufdir), 16'h0);
    checkOutput("ymwr_cs_l", 16'(s.cs_l), 16'h0);
    checkOutput("ymwr_latch", 16'(ym_latch), 16'h00CC);

    $display("[TB] cycles that must not reach the YM3812");
    applyStimulus(0, 0, 0, 1, 16'h0123, 8'h11, s, lows);
    checkOutput("miss123_cs_l", 16'(s.cs_l), 16'h1);
    checkOutput("miss123_sfdbk", 16'(s.sfdbk), 16'h0);
    applyStimulus(0, 0, 0, 1, 16'h0234, 8'h22, s, lows);
    checkOutput("miss234_iow_l", 16'(s.iow_l), 16'h1);
    applyStimulus(0, 1, 1, 0, 16'h0388, 8'h00, s, lows);
    checkOutput("mem388_cs_l", 16'(s.cs_l), 16'h1);
    checkOutput("mem388_sfdbk", 16'(s.sfdbk), 16'h0);
    applyStimulus(0, 0, 1, 1, 16'h0388, 8'h33, s, lows);
    checkOutput("both388_cs_l", 16'(s.cs_l), 16'h1);
    checkOutput("both388_ior_l", 16'(s.ior_l), 16'h1);

    $display("[TB] card disabled");
    applyStimulus(1, 1, 0, 1, 16'h0002, 8'h00, s, lows);
    checkOutput("dis_cden", 16'(cden), 16'h0);
    applyStimulus(0, 0, 1, 0, 16'h0388, 8'h00, s, lows);
    checkOutput("dis_cs_l", 16'(s.cs_l), 16'h1);
    checkOutput("dis_sfdbk", 16'(s.sfdbk), 16'h0);

    $display("[TB] reset during a YM read");
    applyStimulus(1, 1, 0, 1, 16'h0002, 8'h01, s, lows);
    @(posedge clk); #1;
    cd_setup_l = 1'b1; m_io = 1'b0; s1_r_l = 1'b0; s0_w_l = 1'b1; a = 16'h0388; adl_l = 1'b0;
    @(posedge clk); #1;
    adl_l = 1'b1; s1_r_l = 1'b1; cmd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("prerst_ior_l", 16'(ior_l), 16'h0);
    #2;
    chreset_l = 1'b0;
    #1;
    checkOutput("midrst_ior_l", 16'(ior_l), 16'h1);
    checkOutput("midrst_cs_l", 16'(ym_cs_l), 16'h1);
    checkOutput("midrst_bufen_l", 16'(bufen_l), 16'h1);
    checkOutput("midrst_chrdy_l", 16'(cd_chrdy_l), 16'h1);
    checkOutput("midrst_sfdbk", 16'(cd_sfdbk), 16'h0);
    checkOutput("midrst_cden", 16'(cden), 16'h0);
    @(posedge clk); #1;
    cmd = 1'b1; a = 16'h0000; m_io = 1'b1;
    @(posedge clk); #1;
    chreset_l = 1'b1;
    applyStimulus(1, 1, 1, 0, 16'h0002, 8'h00, s, lows);
    checkOutput("postrst_pos2", 16'(s.d), 16'h0000);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
